branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Gshare direction predictor sitting directly upstream of the instruction scheduler; drives its take_flag.
//  Looks up a table of 2-bit saturating counters, indexed by fetch PC XOR global history; answer is ready one cycle later,
//   aligned with the 1-cycle CRAM read data the scheduler checks for BEQ/BLT.
//  Trained by the core at branch resolution; keeps 32-bit prediction/mispredict statistics.
// PARAMETERS
//  IDX_W     6      table index width; table has 2**IDX_W entries
//  GHR_W     4      global history length; GHR_W <= IDX_W required (static assert)
//  CNT_INIT  2'b01  counter value after reset (weakly not-taken)
// PORTS
//  clk             in   1            clock, all state on posedge
//  nrst            in   1            asynchronous active-low reset
//  ce              in   1            fetch enable (scheduler halt); 0 freezes lookup path
//  lookup_valid    in   1            lookup_pc is being issued to CRAM this cycle (arvalid&arready)
//  lookup_pc       in   CRAM_ADDR_W  byte address of fetched word
//  take_flag       out  1            prediction for the word looked up in the previous accepted cycle
//  upd_valid       in   1            one branch resolved this cycle
//  upd_pc          in   CRAM_ADDR_W  byte address of resolved branch
//  upd_taken       in   1            actual direction
//  upd_mispredict  in   1            core flushed fetch for this branch
//  stat_pred       out  32           count of accepted lookups, saturating
//  stat_miss       out  32           count of upd_valid&upd_mispredict, saturating
// BEHAVIOUR
//  Reset (nrst=0, async): all counters=CNT_INIT, ghr=0, take_flag=0, stat_pred=stat_miss=0.
//  Index: idx(pc) = pc[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}; pc[1:0] ignored (word fetch).
//  Lookup: when ce&lookup_valid at cycle N, take_flag at N+1 = cnt[idx(lookup_pc)][1], using ghr at N.
//   If ce=0 or lookup_valid=0: take_flag holds its previous value; stat_pred unchanged.
//   Registered output; no combinational path from any input to take_flag.
//  Update (independent of ce): when upd_valid at cycle N, with i=idx(upd_pc) using ghr at N:
//   cnt[i] <= taken ? min(cnt[i]+1,3) : max(cnt[i]-1,0)   (saturating, 2-bit)
//   ghr <= {ghr[GHR_W-2:0], upd_taken}   (non-speculative; history changes only at resolution)
//   stat_miss += upd_mispredict, saturating at 32'hFFFF_FFFF.
//  Simultaneous lookup & update, same cycle:
//   lookup uses ghr and cnt before the update (old values); no bypass;
//   ordering is fixed so the bench can model it exactly.
//  GHR_W=1 legal: ghr <= upd_taken.
//  stat_pred increments by 1 per accepted lookup, saturating at 32'hFFFF_FFFF.
//  Reset asserted mid-operation: all state returns to reset values immediately; first lookup after release sees CNT_INIT.
//  One update per cycle max; upd_* ignored when upd_valid=0 (X-tolerant).
// TESTING
//  1 reset: nrst low then high; lookup pc=0x40 -> take_flag=0 next cycle, stat_pred=1.
//  2 saturation: 3 updates pc=0x40 taken, ghr forced by history -> counter sequence 1,2,3,3; later lookup at same idx -> take_flag=1.
//  3 history aliasing: IDX_W=6,GHR_W=4; after updates T,T,N,T ghr=4'b1101; lookup pc=0x34 reads entry 0x0D^0x0D=0.
//  4 collision: lookup and update same idx same cycle, cnt=1, update taken -> take_flag=0 (old value); next lookup -> 1.
//  5 halt: ce=0 with lookup_valid=1 for 5 cycles -> take_flag and stat_pred frozen; updates still change cnt/ghr/stat_miss.
//  6 async reset mid-run: assert nrst between edges -> take_flag, ghr, stats 0 without clock edge; counters back to CNT_INIT.

Source files
------------

// File: rtl/branch_predictor.sv
// Gshare direction predictor: 2-bit saturating counters indexed by PC ^ global history,
// one-cycle registered prediction, non-speculative history training and saturating statistics.
module branch_predictor #(
    parameter int         IDX_W       = 6,
    parameter int         GHR_W       = 4,
    parameter int         CRAM_ADDR_W = 16,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   ce,
    input  logic                   lookup_valid,
    input  logic [CRAM_ADDR_W-1:0] lookup_pc,
    output logic                   take_flag,
    input  logic                   upd_valid,
    input  logic [CRAM_ADDR_W-1:0] upd_pc,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict,
    output logic [31:0]            stat_pred,
    output logic [31:0]            stat_miss
);

    localparam int ENTRIES = 1 << IDX_W;

    if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr_w
        $error("branch_predictor: GHR_W must satisfy 1 <= GHR_W <= IDX_W");
    end
    if (CRAM_ADDR_W < IDX_W + 2) begin : g_bad_addr_w
        $error("branch_predictor: CRAM_ADDR_W too narrow for IDX_W");
    end

    // Word index XORed with history; the history is zero-extended into the low index bits.
    function automatic logic [IDX_W-1:0] table_idx(input logic [CRAM_ADDR_W-1:0] pc,
                                                   input logic [GHR_W-1:0]       ghr);
        logic [IDX_W-1:0] ghr_ext;
        ghr_ext              = {IDX_W{1'b0}};
        ghr_ext[GHR_W-1:0]   = ghr;
        return pc[IDX_W+1:2] ^ ghr_ext;
    endfunction

    function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    logic [1:0]       cnt_q [ENTRIES];
    logic [1:0]       cnt_d [ENTRIES];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             take_flag_q, take_flag_d;
    logic [31:0]      stat_pred_q, stat_pred_d;
    logic [31:0]      stat_miss_q, stat_miss_d;

    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [GHR_W-1:0] ghr_shift_s;
    logic             unused_pc_bits_s;

    assign lookup_idx_s     = table_idx(lookup_pc, ghr_q);
    assign upd_idx_s        = table_idx(upd_pc, ghr_q);
    assign unused_pc_bits_s = ^{lookup_pc, upd_pc};

    if (GHR_W == 1) begin : g_ghr_one
        assign ghr_shift_s = upd_taken;
    end else begin : g_ghr_shift
        assign ghr_shift_s = {ghr_q[GHR_W-2:0], upd_taken};
    end

    // Lookup path: samples pre-update table/history, frozen when fetch is halted.
    always_comb begin
        take_flag_d = take_flag_q;
        stat_pred_d = stat_pred_q;
        if (ce && lookup_valid) begin
            take_flag_d = cnt_q[lookup_idx_s][1];
            stat_pred_d = sat_inc32(stat_pred_q);
        end else begin
            take_flag_d = take_flag_q;
            stat_pred_d = stat_pred_q;
        end
    end

    // Training path: runs regardless of ce so resolutions during a halt are not lost.
    always_comb begin
        cnt_d       = cnt_q;
        ghr_d       = ghr_q;
        stat_miss_d = stat_miss_q;
        if (upd_valid) begin
            cnt_d[upd_idx_s] = cnt_train(cnt_q[upd_idx_s], upd_taken);
            ghr_d            = ghr_shift_s;
            if (upd_mispredict) begin
                stat_miss_d = sat_inc32(stat_miss_q);
            end else begin
                stat_miss_d = stat_miss_q;
            end
        end else begin
            ghr_d       = ghr_q;
            stat_miss_d = stat_miss_q;
        end
    end

    // Counter table.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                cnt_q[k] <= CNT_INIT;
            end
        end else begin
            for (int k = 0; k < ENTRIES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // History, prediction output and statistics.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ghr_q       <= {GHR_W{1'b0}};
            take_flag_q <= 1'b0;
            stat_pred_q <= 32'd0;
            stat_miss_q <= 32'd0;
        end else begin
            ghr_q       <= ghr_d;
            take_flag_q <= take_flag_d;
            stat_pred_q <= stat_pred_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign take_flag = take_flag_q;
    assign stat_pred = stat_pred_q;
    assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against an array-based gshare reference model.
module tb_branch_predictor;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          nrst;
    logic          ce;
    logic          lookup_valid;
    logic [AW-1:0] lookup_pc;
    logic          take_flag;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic          upd_mispredict;
    logic [31:0]   stat_pred;
    logic [31:0]   stat_miss;

    int     tests_run    = 0;
    int     tests_failed = 0;

    int     m_cnt [64];
    int     m_ghr;
    bit     m_tf;
    longint m_pred;
    longint m_miss;

    branch_predictor #(
        .IDX_W(6), .GHR_W(4), .CRAM_ADDR_W(AW), .CNT_INIT(2'b01)
    ) dut (
        .clk(clk), .nrst(nrst), .ce(ce),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .take_flag(take_flag),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict),
        .stat_pred(stat_pred), .stat_miss(stat_miss)
    );

    always #5 clk = ~clk;

    function automatic int midx(input int pc, input int g);
        return ((pc >> 2) % 64) ^ g;
    endfunction

    function automatic void model_reset();
        foreach (m_cnt[k]) m_cnt[k] = 1;
        m_ghr  = 0;
        m_tf   = 1'b0;
        m_pred = 0;
        m_miss = 0;
    endfunction

    // Lookup is evaluated first so it sees the table and history before any training.
    function automatic void model_edge();
        int li;
        int ui;
        if (ce && lookup_valid) begin
            li   = midx(int'(lookup_pc), m_ghr);
            m_tf = (m_cnt[li] >= 2);
            if (m_pred < 64'hFFFF_FFFF) m_pred++;
        end
        if (upd_valid) begin
            ui = midx(int'(upd_pc), m_ghr);
            if (upd_taken) m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
            else           m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
            m_ghr = (m_ghr * 2 + int'(upd_taken)) % 16;
            if (upd_mispredict && m_miss < 64'hFFFF_FFFF) m_miss++;
        end
    endfunction

    task automatic idle();
        ce = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        nrst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic lookup(input int pc);
        lookup_valid = 1'b1; lookup_pc = AW'(pc);
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input int pc, input bit taken, input bit mis);
        upd_valid = 1'b1; upd_pc = AW'(pc); upd_taken = taken; upd_mispredict = mis;
        step();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (take_flag !== 1'b0 || stat_pred !== 32'd0 || stat_miss !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: take_flag=%0b stat_pred=%0d stat_miss=%0d, required 0/0/0",
                     take_flag, stat_pred, stat_miss);
        end
        lookup(32'h40);
        tests_run++;
        if (take_flag !== 1'b0 || stat_pred !== 32'd1) begin
            tests_failed++;
            $display("FAIL reset_first_lookup: take_flag=%0b stat_pred=%0d, required 0/1",
                     take_flag, stat_pred);
        end
    endtask

    task automatic test_saturation();
        bit exp_tf [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit dirs   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            update((16 ^ m_ghr) << 2, dirs[k], 1'b0);
            lookup((16 ^ m_ghr) << 2);
            tests_run++;
            if (take_flag !== exp_tf[k]) begin
                tests_failed++;
                $display("FAIL saturation_step%0d: take_flag=%0b, required %0b", k, take_flag, exp_tf[k]);
            end
        end
    endtask

    task automatic test_aliasing();
        do_reset();
        update(32'h00, 1'b1, 1'b0);
        update(32'h04, 1'b1, 1'b0);
        update(32'h0C, 1'b0, 1'b1);
        update(32'h18, 1'b1, 1'b0);
        lookup(32'h34);
        tests_run++;
        if (take_flag !== 1'b1 || stat_miss !== 32'd1) begin
            tests_failed++;
            $display("FAIL alias_entry0: take_flag=%0b stat_miss=%0d, required 1/1", take_flag, stat_miss);
        end
        lookup(32'h00);
        tests_run++;
        if (take_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL alias_entry13: take_flag=%0b, required 0", take_flag);
        end
    endtask

    task automatic test_collision();
        do_reset();
        lookup_valid = 1'b1; lookup_pc = 16'h0080;
        upd_valid = 1'b1; upd_pc = 16'h0080; upd_taken = 1'b1;
        step();
        idle();
        tests_run++;
        if (take_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_old: take_flag=%0b, required 0", take_flag);
        end
        lookup(32'h84);
        tests_run++;
        if (take_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_new: take_flag=%0b, required 1", take_flag);
        end
    endtask

    task automatic test_halt();
        do_reset();
        update(32'h00, 1'b1, 1'b0);
        lookup(32'h04);
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lookup_valid = 1'b1; lookup_pc = AW'($urandom_range(0, 255) * 4);
            upd_valid = 1'b1; upd_pc = AW'($urandom_range(0, 255) * 4);
            upd_taken = 1'($urandom_range(0, 1)); upd_mispredict = 1'b1;
            step();
            tests_run++;
            if (take_flag !== 1'b1 || stat_pred !== 32'd1 || stat_miss !== 32'(k + 1)) begin
                tests_failed++;
                $display("FAIL halt_cycle%0d: take_flag=%0b stat_pred=%0d stat_miss=%0d, required 1/1/%0d",
                         k, take_flag, stat_pred, stat_miss, k + 1);
            end
        end
        idle();
        for (int k = 0; k < 8; k++) begin
            lookup($urandom_range(0, 15) * 4);
            tests_run++;
            if (take_flag !== m_tf) begin
                tests_failed++;
                $display("FAIL halt_after%0d: take_flag=%0b, required %0b", k, take_flag, m_tf);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            ce             = ($urandom_range(0, 7) != 0);
            lookup_valid   = 1'($urandom_range(0, 1));
            lookup_pc      = AW'($urandom_range(0, 16'hFFFF));
            upd_valid      = 1'($urandom_range(0, 1));
            upd_pc         = AW'($urandom_range(0, 16'hFFFF));
            upd_taken      = ($urandom_range(0, 3) != 0);
            upd_mispredict = 1'($urandom_range(0, 1));
            step();
            tests_run++;
            if (take_flag !== m_tf || stat_pred !== 32'(m_pred) || stat_miss !== 32'(m_miss)) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: take_flag=%0b stat_pred=%0d stat_miss=%0d, required %0b/%0d/%0d",
                         k, take_flag, stat_pred, stat_miss, m_tf, m_pred, m_miss);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        update(32'h00, 1'b1, 1'b1);
        update(32'h04, 1'b1, 1'b1);
        lookup(32'h0C);
        tests_run++;
        if (take_flag !== 1'b1 || stat_miss !== 32'd2) begin
            tests_failed++;
            $display("FAIL async_pre: take_flag=%0b stat_miss=%0d, required 1/2", take_flag, stat_miss);
        end
        #2;
        nrst = 1'b0;
        #1;
        tests_run++;
        if (take_flag !== 1'b0 || stat_pred !== 32'd0 || stat_miss !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_no_edge: take_flag=%0b stat_pred=%0d stat_miss=%0d, required 0/0/0",
                     take_flag, stat_pred, stat_miss);
        end
        model_reset();
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        lookup(32'h00);
        tests_run++;
        if (take_flag !== 1'b0 || stat_pred !== 32'd1) begin
            tests_failed++;
            $display("FAIL async_cnt_init: take_flag=%0b stat_pred=%0d, required 0/1", take_flag, stat_pred);
        end
        update(32'h00, 1'b1, 1'b0);
        lookup(32'h04);
        tests_run++;
        if (take_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_ghr_cleared: take_flag=%0b, required 1", take_flag);
        end
    endtask

    initial begin
        nrst = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_saturation();
        test_aliasing();
        test_collision();
        test_halt();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
